// File: rtl/pipe_stage_skid.sv
// Parametrised valid/ready pipeline stage with a 2-entry skid buffer.
// Optional stall/flush counters: define PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W    = 128,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int unsigned       PERF_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
`ifdef PIPE_STAGE_SKID_PERF_EN
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o,
`endif
    output logic [DATA_W-1:0] out_data_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire     = in_valid_i & in_ready_q;
    assign out_fire    = out_valid_q & out_ready_i;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;

    // main_q always holds the older beat; skid_q only fills in TWO
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= EMPTY;
            main_q      <= FLUSH_VAL;
            skid_q      <= FLUSH_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            state_q     <= EMPTY;
            main_q      <= FLUSH_VAL;
            skid_q      <= FLUSH_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q     <= ONE;
                        main_q      <= in_data_i;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data_i;
                    end else if (in_fire) begin
                        state_q    <= TWO;
                        skid_q     <= in_data_i;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_q    <= ONE;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    // saturating counters, deliberately untouched by flush
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid_q && !out_ready_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (flush_i && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: vector table, hand sequences, random scoreboard.
// Define PIPE_STAGE_SKID_PERF_EN to also exercise the counters.
module tb_pipe_stage_skid;

    localparam int W = 128;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [3:0]   stall_cnt;
    logic [3:0]   flush_cnt;
`endif

    pipe_stage_skid #(
        .DATA_W    (W),
        .FLUSH_VAL ('0),
        .PERF_W    (4)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
`ifdef PIPE_STAGE_SKID_PERF_EN
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt),
`endif
        .out_data_o  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         f;
        logic         ev;
        logic         er;
        logic [W-1:0] ed;
    } vec_t;

    vec_t         tbl[7];
    logic [W-1:0] sb_q[$];
    logic         sb_clean;
    logic         acc;
    int           n_checks;
    int           n_errors;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one cycle: drive, check against scoreboard, clock, update scoreboard
    task automatic step(input logic v, input logic [W-1:0] d,
                        input logic r, input logic f);
        logic ifire;
        logic ofire;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
        chk("out_valid", W'(out_valid), W'(sb_q.size() != 0));
        chk("in_ready", W'(in_ready), W'(sb_q.size() < 2));
        if (sb_q.size() != 0) chk("out_data", out_data, sb_q[0]);
        else if (sb_clean) chk("flush_val", out_data, '0);
        ifire = v && (sb_q.size() < 2);
        ofire = r && (sb_q.size() != 0);
        @(posedge clk);
        if (ofire) void'(sb_q.pop_front());
        if (f) begin
            sb_q.delete();
            sb_clean = 1'b1;
        end else if (ifire) begin
            sb_q.push_back(d);
            sb_clean = 1'b0;
        end
        acc = ifire;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_data", out_data, '0);
        sb_q.delete();
        sb_clean = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic         hv;
        logic [W-1:0] hd;
        logic         r;
        logic         f;

        n_checks  = 0;
        n_errors  = 0;
        sb_clean  = 1'b1;
        acc       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b1;

        tbl[0] = '{1'b1, W'('hA), 1'b0, 1'b0, 1'b0, 1'b1, W'(0)};
        tbl[1] = '{1'b1, W'('hB), 1'b0, 1'b0, 1'b1, 1'b1, W'('hA)};
        tbl[2] = '{1'b1, W'('hC), 1'b0, 1'b0, 1'b1, 1'b0, W'('hA)};
        tbl[3] = '{1'b1, W'('hC), 1'b1, 1'b0, 1'b1, 1'b0, W'('hA)};
        tbl[4] = '{1'b1, W'('hC), 1'b1, 1'b0, 1'b1, 1'b1, W'('hB)};
        tbl[5] = '{1'b0, W'(0),   1'b1, 1'b0, 1'b1, 1'b1, W'('hC)};
        tbl[6] = '{1'b0, W'(0),   1'b1, 1'b0, 1'b0, 1'b1, W'(0)};

        @(negedge clk);
        do_reset();

        // streaming
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // backpressure from the vector table
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("tbl%0d_valid", i), W'(out_valid), W'(tbl[i].ev));
            chk($sformatf("tbl%0d_ready", i), W'(in_ready), W'(tbl[i].er));
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
            step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
        end

        // flush in TWO with a beat offered
        step(1'b1, W'('h11), 1'b0, 1'b0);
        step(1'b1, W'('h22), 1'b0, 1'b0);
        step(1'b1, W'('hD), 1'b0, 1'b1);
        chk("flush_two_valid", W'(out_valid), '0);
        step(1'b0, '0, 1'b1, 1'b0);

        // flush in ONE while a beat fires in
        step(1'b1, W'('h33), 1'b0, 1'b0);
        step(1'b1, W'('hD), 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

        // flush together with an out_fire
        step(1'b1, W'('h44), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

        // stall hold
        step(1'b1, W'('h55), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // random traffic with upstream holding unaccepted beats
        for (int i = 0; i < 300; i++) begin
            if (acc || !hv) begin
                hv = ($urandom_range(0, 9) < 7);
                hd = {$urandom, $urandom, $urandom, $urandom};
            end
            r = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 29) == 0);
            step(hv, hd, r, f);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // async reset mid-stream in TWO
        step(1'b1, W'('h66), 1'b0, 1'b0);
        step(1'b1, W'('h67), 1'b0, 1'b0);
        chk("pre_rst_ready", W'(in_ready), '0);
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_SKID_PERF_EN
        chk("stall_cnt_rst", W'(stall_cnt), '0);
        chk("flush_cnt_rst", W'(flush_cnt), '0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, W'('h77), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("stall_cnt_sat", W'(stall_cnt), W'('hF));
        chk("flush_cnt", W'(flush_cnt), W'(3));
        step(1'b0, '0, 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
